branch_predictor: RTL

- Parametrised dynamic branch predictor with branch target buffer (BTB) for the 16-bit pipelined core.
- Replaces fixed predict-not-taken fetch; IF consults it each cycle with the fetch PC.
- EX/MEM stage writes resolved branch outcomes back into it.
- Selectable prediction mode; saturating statistics counters for debug.

---
 rtl/pmips_pkg.sv | 30 +++
 rtl/sat_counter2.sv | 23 ++
 rtl/branch_predictor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pmips_pkg.sv
// Shared constants for the pmips core: predictor modes, 2-bit counter
// encodings and the halfword instruction alignment offset.
// Pure package; no logic, no ports.
package pmips_pkg;

    // Prediction modes selected by branch_predictor.MODE
    localparam int MODE_STATIC = 0;
    localparam int MODE_1BIT   = 1;
    localparam int MODE_2BIT   = 2;

    // 2-bit counter encodings; the MSB is the 2-bit taken decision
    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Instructions are halfword aligned, so pc[0] never selects an entry
    localparam int HW_OFS = 1;

    // Taken decision from a stored counter for the given mode
    function automatic logic taken_bit(input int mode, input logic [1:0] ctr);
        if (mode == MODE_2BIT)
            return ctr[1];
        else if (mode == MODE_1BIT)
            return ctr[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state function with parallel load.
// Ports: cur (present value), load/load_val (override), up/down (step), nxt.
// Purely combinational; load wins over up, up wins over down; no wrap at 0 or 3.
module sat_counter2 (
    input  logic [1:0] cur,
    input  logic       load,
    input  logic [1:0] load_val,
    input  logic       up,
    input  logic       down,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (load)
            nxt = load_val;
        else if (up && (cur != 2'b11))
            nxt = cur + 2'd1;
        else if (down && (cur != 2'b00))
            nxt = cur - 2'd1;
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with flop-based BTB for the 16-bit pipelined core.
// Ports: clock/reset (sync, active low); lookup_pc -> pred_hit/pred_taken/pred_target
// (combinational); upd_* resolved-branch write port; mispredict flag and saturating stats.
module branch_predictor
    import pmips_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int MODE    = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - HW_OFS;

    // A fresh allocation starts as weakly taken; 1-bit mode has no "weak"
    // state, so both bits are set to make ctr[0] read as taken.
    localparam logic [1:0] ALLOC_CTR = (MODE == MODE_1BIT) ? STRONG_T : WEAK_T;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;

    logic [ENTRIES-1:0] wr_en;
    logic [ENTRIES-1:0] tgt_wr;
    logic [1:0]         ctr_nxt [ENTRIES];

    logic unused_pc_lsb;

    assign lk_idx  = lookup_pc[IDX_W-1+HW_OFS:HW_OFS];
    assign lk_tag  = lookup_pc[ADDR_W-1:IDX_W+HW_OFS];
    assign upd_idx = upd_pc[IDX_W-1+HW_OFS:HW_OFS];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+HW_OFS];

    assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

    // Lookup reads the registered table, so a same-cycle update to the same
    // entry is only seen from the following cycle (read-before-write).
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && taken_bit(MODE, ctr_q[lk_idx]);
        pred_target = pred_hit ? target_q[lk_idx] : '0;
    end

    // Per-entry next state. A not-taken miss never allocates, so a useful
    // entry is only evicted by a taken branch that aliases onto it.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        logic sel;
        logic hit_u;
        logic ld;
        logic [1:0] ld_val;

        assign sel    = upd_valid && (upd_idx == IDX_W'(i));
        assign hit_u  = valid_q[i] && (tag_q[i] == upd_tag);
        assign ld     = !hit_u || (MODE == MODE_1BIT);
        assign ld_val = hit_u ? {upd_taken, upd_taken} : ALLOC_CTR;

        sat_counter2 u_ctr (
            .cur      (ctr_q[i]),
            .load     (ld),
            .load_val (ld_val),
            .up       (hit_u && upd_taken),
            .down     (hit_u && !upd_taken),
            .nxt      (ctr_nxt[i])
        );

        assign wr_en[i]  = sel && (hit_u || upd_taken);
        // Not-taken branches compute no useful target; keep the old one.
        assign tgt_wr[i] = upd_taken;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= STRONG_NT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_en[i]) begin
                    valid_q[i] <= 1'b1;
                    tag_q[i]   <= upd_tag;
                    ctr_q[i]   <= ctr_nxt[i];
                    if (tgt_wr[i])
                        target_q[i] <= upd_target;
                end
            end
        end
    end

    logic upd_miss;
    assign upd_miss = upd_valid && (upd_taken != upd_pred_taken);

    always_ff @(posedge clock) begin
        if (!reset) begin
            mispredict       <= 1'b0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            mispredict <= upd_miss;
            if (upd_valid && (stat_branches != '1))
                stat_branches <= stat_branches + 1'b1;
            if (upd_miss && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule
